// File: rtl/seg_scan_ctrl_if.sv
// Handshake and display-drive bundle between the value source and the scan controller.
interface seg_scan_ctrl_if #(
   parameter int unsigned DIGITS = 4
);
   logic [4*DIGITS-1:0] din;
   logic                dvalid;
   logic                dready;
   logic                lzb;
   logic [3:0]          hex;
   logic                segen;
   logic [DIGITS-1:0]   an;
   logic                frame;

   // Source side: supplies the value and the blanking enable.
   modport master (
      output din, dvalid, lzb,
      input  dready, hex, segen, an, frame
   );

   // Controller side.
   modport slave (
      input  din, dvalid, lzb,
      output dready, hex, segen, an, frame
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-aligned value update,
// per-slot blanking guard and leading-zero blanking.
module seg_scan_ctrl #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned DWELL  = 1000,
   parameter int unsigned GUARD  = 16
) (
   input  logic          clk,
   input  logic          rst,
   seg_scan_ctrl_if.slave bus
);

   localparam int unsigned CW = (DWELL > 1)  ? $clog2(DWELL)  : 1;
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned DW = 4 * DIGITS;

   logic [CW-1:0]     cnt;
   logic [IW-1:0]     idx;
   logic [DW-1:0]     disp;
   logic [DW-1:0]     pend;
   logic              pend_full;
   logic              dready_q;
   logic [3:0]        hex_q;
   logic              segen_q;
   logic [DIGITS-1:0] an_q;
   logic              frame_q;

   logic              slot_end;
   logic              frame_end;
   logic              xfer;
   logic              in_guard;
   logic              blank;
   logic [3:0]        nib;
   logic [DIGITS-1:0] sel;

   // Slot/frame decode, handshake, nibble select and leading-zero test.
   always_comb begin
      slot_end  = (cnt == CW'(DWELL - 1));
      frame_end = slot_end && (idx == IW'(DIGITS - 1));
      xfer      = bus.dvalid && dready_q;
      in_guard  = (32'(cnt) < GUARD);
      nib       = disp[4*int'(idx) +: 4];
      sel       = ~(DIGITS'(1) << idx);
      blank     = 1'b0;
      if (bus.lzb && (idx != '0)) begin
         blank = 1'b1;
         for (int k = 0; k < int'(DIGITS); k++) begin
            if ((k >= int'(idx)) && (disp[4*k +: 4] != 4'h0)) begin
               blank = 1'b0;
            end
         end
      end
   end

   // Dwell counter and digit-slot index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // One-deep pending buffer; display register only changes at frame end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp      <= '0;
         pend      <= '0;
         pend_full <= 1'b0;
         dready_q  <= 1'b1;
      end else if (frame_end && pend_full) begin
         disp      <= pend;
         pend_full <= 1'b0;
         dready_q  <= 1'b1;
      end else if (xfer) begin
         pend      <= bus.din;
         pend_full <= 1'b1;
         dready_q  <= 1'b0;
      end
   end

   // Registered display drive; reflects the previous cycle's slot position.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hex_q   <= 4'h0;
         segen_q <= 1'b0;
         an_q    <= '1;
         frame_q <= 1'b0;
      end else begin
         hex_q   <= nib;
         segen_q <= !in_guard && !blank;
         an_q    <= in_guard ? '1 : sel;
         frame_q <= frame_end;
      end
   end

   assign bus.dready = dready_q;
   assign bus.hex    = hex_q;
   assign bus.segen  = segen_q;
   assign bus.an     = an_q;
   assign bus.frame  = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: vector table, corner sequences and random traffic
// against a time-indexed reference model.
module tb_seg_scan_ctrl;

   localparam int DIGITS = 4;
   localparam int DWELL  = 8;
   localparam int GUARD  = 2;
   localparam int FRAMEL = DIGITS * DWELL;

   logic clk;
   logic rst;

   seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

   seg_scan_ctrl #(
      .DIGITS(DIGITS),
      .DWELL (DWELL),
      .GUARD (GUARD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] val;
      logic        lzb;
      logic [15:0] hex;   // expected HEX per slot, slot k in nibble k
      logic [3:0]  lit;   // expected SEGEN per slot
   } vec_t;

   vec_t        tab[6];
   int          n_cmp;
   int          n_bad;
   int          edges;
   logic [15:0] m_disp;
   logic [15:0] m_pq[$];
   logic [15:0] src_q[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d, t=%0t)", name, got, exp, edges, $time);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_an"},     32'(bus.an),     32'hF);
      chk({tag, "_hex"},    32'(bus.hex),    32'h0);
      chk({tag, "_segen"},  32'(bus.segen),  32'h0);
      chk({tag, "_frame"},  32'(bus.frame),  32'h0);
      chk({tag, "_dready"}, 32'(bus.dready), 32'h1);
   endtask

   task automatic drive_src();
      bus.dvalid = (src_q.size() > 0);
      bus.din    = (src_q.size() > 0) ? src_q[0] : 16'h0;
   endtask

   // Hold reset over one edge and release on a falling edge.
   task automatic finish_reset(input string tag);
      bus.dvalid = 1'b0;
      src_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      edges  = 0;
      m_disp = 16'h0;
      m_pq.delete();
      chk_reset(tag);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      finish_reset("rel");
   endtask

   // Asynchronous assertion between edges; outputs must clear without a clock.
   task automatic async_reset();
      #($urandom_range(1, 3));
      rst = 1'b1;
      #1;
      chk_reset("async");
      finish_reset("arel");
   endtask

   // One clock: predict from elapsed time and model state, then compare.
   task automatic cycle();
      int          s;
      int          cnt;
      int          idx;
      logic [15:0] upper;
      logic [3:0]  e_an;
      logic [3:0]  e_hex;
      logic        e_seg;
      logic        e_frame;
      logic        e_rdy;
      @(posedge clk);
      s     = edges;
      cnt   = s % DWELL;
      idx   = (s / DWELL) % DIGITS;
      upper = m_disp >> (4 * idx);
      e_hex = upper[3:0];
      if (cnt < GUARD) begin
         e_an  = 4'hF;
         e_seg = 1'b0;
      end else begin
         e_an  = 4'hF & ~(4'(1) << idx);
         e_seg = !(bus.lzb && (idx != 0) && (upper == 16'h0));
      end
      e_frame = ((s % FRAMEL) == FRAMEL - 1);
      if (e_frame && (m_pq.size() > 0)) begin
         m_disp = m_pq.pop_front();
      end else if (bus.dvalid && (m_pq.size() == 0)) begin
         m_pq.push_back(bus.din);
         void'(src_q.pop_front());
      end
      e_rdy = (m_pq.size() == 0);
      edges++;
      @(negedge clk);
      chk("an",     32'(bus.an),     32'(e_an));
      chk("hex",    32'(bus.hex),    32'(e_hex));
      chk("segen",  32'(bus.segen),  32'(e_seg));
      chk("frame",  32'(bus.frame),  32'(e_frame));
      chk("dready", 32'(bus.dready), 32'(e_rdy));
      drive_src();
   endtask

   // Load a value right after reset, then sample the first SHOW cycle of each slot in frame 2.
   task automatic run_vector(input int v);
      apply_reset();
      bus.lzb = tab[v].lzb;
      src_q.push_back(tab[v].val);
      drive_src();
      for (int c = 0; c < 2 * FRAMEL; c++) begin
         cycle();
         if (edges == FRAMEL) chk("vec_frame_pulse", 32'(bus.frame), 32'h1);
         for (int k = 0; k < DIGITS; k++) begin
            if (edges == FRAMEL + 1 + k * DWELL + GUARD) begin
               logic [15:0] h;
               h = tab[v].hex >> (4 * k);
               chk($sformatf("vec%0d_s%0d_hex", v, k), 32'(bus.hex), 32'(h[3:0]));
               chk($sformatf("vec%0d_s%0d_seg", v, k), 32'(bus.segen), 32'(tab[v].lit[k]));
               chk($sformatf("vec%0d_s%0d_an", v, k), 32'(bus.an), 32'(4'hF & ~(4'(1) << k)));
            end
         end
      end
   endtask

   initial begin
      n_cmp      = 0;
      n_bad      = 0;
      edges      = 0;
      m_disp     = 16'h0;
      rst        = 1'b1;
      bus.din    = 16'h0;
      bus.dvalid = 1'b0;
      bus.lzb    = 1'b0;

      tab[0] = '{val: 16'h1234, lzb: 1'b0, hex: 16'h1234, lit: 4'b1111};
      tab[1] = '{val: 16'h0050, lzb: 1'b1, hex: 16'h0050, lit: 4'b0011};
      tab[2] = '{val: 16'h0000, lzb: 1'b1, hex: 16'h0000, lit: 4'b0001};
      tab[3] = '{val: 16'h0000, lzb: 1'b0, hex: 16'h0000, lit: 4'b1111};
      tab[4] = '{val: 16'hAF0B, lzb: 1'b1, hex: 16'hAF0B, lit: 4'b1111};
      tab[5] = '{val: 16'h0050, lzb: 1'b0, hex: 16'h0050, lit: 4'b1111};

      // Reset state and guard-then-show timing of the first slot.
      apply_reset();
      for (int c = 0; c < GUARD + 1; c++) begin
         cycle();
         if (edges <= GUARD) chk("first_guard_an", 32'(bus.an), 32'hF);
      end
      chk("first_show_an",    32'(bus.an),    32'hE);
      chk("first_show_hex",   32'(bus.hex),   32'h0);
      chk("first_show_segen", 32'(bus.segen), 32'h1);

      for (int v = 0; v < 6; v++) run_vector(v);

      // Back-pressure: second value held off until the frame end frees pending.
      apply_reset();
      src_q.push_back(16'h1111);
      src_q.push_back(16'h2222);
      drive_src();
      for (int c = 0; c < 3 * FRAMEL; c++) begin
         cycle();
         if (edges == 1)                  chk("bp_full",     32'(bus.dready), 32'h0);
         if (edges == FRAMEL - 1)         chk("bp_held",     32'(bus.dready), 32'h0);
         if (edges == FRAMEL)             chk("bp_freed",    32'(bus.dready), 32'h1);
         if (edges == FRAMEL + 1)         chk("bp_accept",   32'(bus.dready), 32'h0);
         if (edges == FRAMEL + 1 + GUARD) chk("bp_show1",    32'(bus.hex),    32'h1);
         if (edges == 2*FRAMEL + 1 + GUARD) chk("bp_show2",  32'(bus.hex),    32'h2);
      end

      // Transfer into empty pending on the frame-end edge: shown one frame late.
      apply_reset();
      for (int c = 0; c < FRAMEL - 1; c++) cycle();
      src_q.push_back(16'h5678);
      drive_src();
      for (int c = 0; c < 2 * FRAMEL + 4; c++) begin
         cycle();
         if (edges == FRAMEL)               chk("sim_taken",   32'(bus.dready), 32'h0);
         if (edges == FRAMEL + 1 + GUARD)   chk("sim_old",     32'(bus.hex),    32'h0);
         if (edges == 2*FRAMEL + 1 + GUARD) chk("sim_new",     32'(bus.hex),    32'h8);
      end

      // Random traffic, LZB toggling and occasional asynchronous resets.
      apply_reset();
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 9) == 0) bus.lzb = ~bus.lzb;
         if ((src_q.size() == 0) && ($urandom_range(0, 29) == 0)) begin
            logic [15:0] r;
            r = 16'($urandom);
            case ($urandom_range(0, 3))
               0: r = r & 16'h000F;
               1: r = r & 16'h00FF;
               2: r = r & 16'h0F0F;
               default: ;
            endcase
            src_q.push_back(r);
            drive_src();
         end
         if ($urandom_range(0, 599) == 0) async_reset();
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
